decoder_nxm_hold: RTL and testbench
===================================

# decoder_nxm_hold

Parametrised, registered binary-to-one-hot decoder with a valid/ready input handshake and a programmable output hold time. A generalisation of the team's 2-to-4 decoder: arbitrary select width, non-power-of-two output count, and a timed output pulse instead of purely combinational decoding. Used wherever a decoded strobe must drive a one-hot select line, such as a bank or channel select, for a fixed number of cycles.

## Interface
- SEL_W, default 2: select width in bits; must be ≥1.
- NUM_OUT, default 4: number of decoded outputs; must satisfy 2 ≤ NUM_OUT ≤ 2**SEL_W.
- HOLD_CYCLES, default 1: cycles each decoded output stays asserted; must be ≥1.
- clk  in  1: single clock; all logic is rising-edge.
- rst  in  1: synchronous, active-high reset.
- en  in  1: block enable; when low, no new select is accepted and an active hold is aborted.
- in_valid  in  1: `sel` is valid this cycle.
- in_ready  out  1: block can accept `sel` this cycle.
- sel  in  SEL_W: binary index to decode.
- y  out  [0:NUM_OUT-1]: one-hot output, ascending range; `y[k]` is asserted for `sel == k`, so `y[0]` is the MSB.
- out_valid  out  1: `y` holds a decoded value.
- err  out  1: out-of-range flag. Present only with `DECODER_RANGE_CHECK_EN`.

## Operation
- State machine with two states, IDLE and HOLD, plus a hold counter `cnt` of width `$clog2(HOLD_CYCLES+1)`.
- `in_ready = en && (state == IDLE || cnt == 1)`. This allows a new select to be accepted back-to-back in the final hold cycle.
- A select is accepted on a rising edge where `in_valid && in_ready`. On that edge:
  - `y` is loaded with the one-hot of `sel`;
  - `out_valid` is set to 1;
  - `cnt` is loaded with HOLD_CYCLES;
  - the state moves to HOLD.
- HOLD, no accept this edge:
  - `cnt > 1`: `cnt` decrements; `y` and `out_valid` hold.
  - `cnt == 1`: the state moves to IDLE; `y` and `out_valid` clear to 0.
- HOLD, accept on the final cycle: the new value is loaded with no gap cycle, so `out_valid` stays 1.
- `en == 0` in HOLD: on the next edge the state moves to IDLE, `y` clears to 0 and `out_valid` clears to 0. The hold time is not completed.
- Out-of-range select (`sel >= NUM_OUT`, possible only when NUM_OUT < 2**SEL_W):
  - The select is still accepted and the hold still runs.
  - `y` is all-zero, but `out_valid` is 1.
- `y` is always one-hot or all-zero; it never has more than one bit set.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `y` = 0, `out_valid` = 0, `err` = 0. While `rst` is high, `in_ready` = 0.
- Reset while in HOLD aborts the hold; all outputs read the reset values from the next edge.
- Latency: `y` and `out_valid` are valid on the cycle after the accepting edge.
- Each accepted select is visible for exactly HOLD_CYCLES cycles, unless it is aborted by `en` or `rst`.
- Throughput: one select per HOLD_CYCLES cycles. With HOLD_CYCLES = 1, one select per cycle.
- `in_ready` is combinational from the state, `cnt` and `en`. All other outputs are registered.
- When `rst` and `en = 0` occur together, reset has priority.

## Configuration
- `DECODER_RANGE_CHECK_EN` defined:
  - The `err` port exists.
  - `err` is registered and loaded on every accepting edge with `(sel >= NUM_OUT)`.
  - `err` holds and clears exactly as `out_valid` does.
- `DECODER_RANGE_CHECK_EN` undefined:
  - There is no `err` port and no range-check logic.
  - Out-of-range selects silently produce an all-zero `y` with `out_valid` = 1.

## Structure
- Shared package `decoder_pkg`, containing:
  - the state enum type, with values IDLE and HOLD;
  - the function `onehot_f(sel, NUM_OUT)`, which returns all-zero for out-of-range input.
- One sub-module, `decoder_onehot`: a purely combinational SEL_W-to-NUM_OUT decoder with an enable input.
- The top level (`decoder_nxm_hold`) owns the FSM, the counter and the output registers.

## Test plan
- Reset, then SEL_W=2, NUM_OUT=4, HOLD_CYCLES=1; `sel` = 0, 1, 2, 3 on consecutive cycles with `in_valid` held high → `y` = 1000, 0100, 0010, 0001 one cycle later each, with `out_valid` high throughout.
- HOLD_CYCLES=3; `sel` = 2 accepted → `y[2]` high for exactly 3 cycles; `in_ready` is low in hold cycles 1–2 and high in cycle 3.
- HOLD_CYCLES=3; `sel` = 1, then `sel` = 3 presented continuously → `y[3]` replaces `y[1]` with no gap cycle.
- SEL_W=3, NUM_OUT=5; `sel` = 6 → `y` = 00000, `out_valid` = 1, and `err` = 1 when `DECODER_RANGE_CHECK_EN` is defined.
- HOLD_CYCLES=4; `en` dropped in hold cycle 2 → `y` = 0 and `out_valid` = 0 on the next edge; `in_ready` = 0 while `en` is low.
- `rst` asserted mid-hold together with `in_valid` → all outputs at reset values on the next edge, and nothing is accepted.

Source files
------------

// File: rtl/decoder_nxm_hold_pkg.sv
// Shared types and helpers for the hold-time one-hot decoder.
// The DECODER_RANGE_CHECK_EN build option is handled in the interface and top level.
package decoder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int unsigned MAX_OUT = 64;

   // Ascending result: bit k set when sel == k; out-of-range selects decode to zero.
   function automatic logic [0:MAX_OUT-1] onehot_f(input int unsigned sel,
                                                   input int unsigned num_out);
      logic [0:MAX_OUT-1] r;
      r = '0;
      for (int unsigned k = 0; k < MAX_OUT; k++) begin
         r[k] = (k < num_out) && (sel == k);
      end
      return r;
   endfunction

endpackage

// File: rtl/decoder_nxm_hold_if.sv
// Select handshake and decoded-output bundle for decoder_nxm_hold.
// The err signal exists only when DECODER_RANGE_CHECK_EN is defined.
interface decoder_nxm_hold_if #(
   parameter int SEL_W   = 2,
   parameter int NUM_OUT = 4
) ();
   logic               en;
   logic               in_valid;
   logic               in_ready;
   logic [SEL_W-1:0]   sel;
   logic [0:NUM_OUT-1] y;
   logic               out_valid;
`ifdef DECODER_RANGE_CHECK_EN
   logic               err;

   modport master (output en, in_valid, sel, input in_ready, y, out_valid, err);
   modport slave  (input en, in_valid, sel, output in_ready, y, out_valid, err);
`else
   modport master (output en, in_valid, sel, input in_ready, y, out_valid);
   modport slave  (input en, in_valid, sel, output in_ready, y, out_valid);
`endif
endinterface

// File: rtl/decoder_nxm_hold_onehot.sv
// Combinational SEL_W-to-NUM_OUT one-hot decoder with enable.
// Output is ascending: y[k] set for sel == k, all-zero when disabled or out of range.
module decoder_onehot
   import decoder_pkg::*;
#(
   parameter int SEL_W   = 2,
   parameter int NUM_OUT = 4
) (
   input  logic               en,
   input  logic [SEL_W-1:0]   sel,
   output logic [0:NUM_OUT-1] y
);
   logic [0:MAX_OUT-1] y_all;

   assign y_all = onehot_f(32'(sel), NUM_OUT);
   assign y     = en ? y_all[0:NUM_OUT-1] : '0;

   generate
      if (NUM_OUT < MAX_OUT) begin : g_tail
         logic unused_tail;
         assign unused_tail = ^y_all[NUM_OUT:MAX_OUT-1];
      end
   endgenerate
endmodule

// File: rtl/decoder_nxm_hold.sv
// Registered binary-to-one-hot decoder holding each decoded strobe for HOLD_CYCLES.
// Optional registered out-of-range flag when DECODER_RANGE_CHECK_EN is defined.
//
//   state | meaning
//   IDLE  | no decoded value on y; ready whenever en is high
//   HOLD  | y/out_valid held; cnt counts remaining cycles, ready on the last one
module decoder_nxm_hold
   import decoder_pkg::*;
#(
   parameter int SEL_W       = 2,
   parameter int NUM_OUT     = 4,
   parameter int HOLD_CYCLES = 1
) (
   input logic              clk,
   input logic              rst,
   decoder_nxm_hold_if.slave bus
);
   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [0:NUM_OUT-1] y_q, y_nxt, y_dec;
   logic               ov_q, ov_nxt;
   logic               last, accept;

   assign last         = (cnt == CNT_ONE);
   assign bus.in_ready = !rst && bus.en && ((state == IDLE) || last);
   assign accept       = bus.in_valid && bus.in_ready;

   decoder_onehot #(
      .SEL_W   (SEL_W),
      .NUM_OUT (NUM_OUT)
   ) u_onehot (
      .en  (accept),
      .sel (bus.sel),
      .y   (y_dec)
   );

`ifdef DECODER_RANGE_CHECK_EN
   logic err_q, err_nxt, oor;
   assign oor     = (32'(bus.sel) >= NUM_OUT);
   assign bus.err = err_q;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      y_nxt     = y_q;
      ov_nxt    = ov_q;
`ifdef DECODER_RANGE_CHECK_EN
      err_nxt   = err_q;
`endif
      if (accept) begin
         state_nxt = HOLD;
         cnt_nxt   = CNT_LOAD;
         y_nxt     = y_dec;
         ov_nxt    = 1'b1;
`ifdef DECODER_RANGE_CHECK_EN
         err_nxt   = oor;
`endif
      end else if (state == HOLD) begin
         // Dropping en aborts the hold; otherwise the final cycle releases it.
         if (!bus.en || last) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            y_nxt     = '0;
            ov_nxt    = 1'b0;
`ifdef DECODER_RANGE_CHECK_EN
            err_nxt   = 1'b0;
`endif
         end else begin
            cnt_nxt = cnt - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         y_q   <= '0;
         ov_q  <= 1'b0;
`ifdef DECODER_RANGE_CHECK_EN
         err_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         y_q   <= y_nxt;
         ov_q  <= ov_nxt;
`ifdef DECODER_RANGE_CHECK_EN
         err_q <= err_nxt;
`endif
      end
   end

   assign bus.y         = y_q;
   assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_decoder_nxm_hold.sv
// Scoreboard bench for decoder_nxm_hold across three parameter sets.
// The err output is compared only when DECODER_RANGE_CHECK_EN is defined.
module tb_decoder_nxm_hold;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   decoder_nxm_hold_if #(.SEL_W(2), .NUM_OUT(4)) bus_a ();
   decoder_nxm_hold_if #(.SEL_W(2), .NUM_OUT(4)) bus_b ();
   decoder_nxm_hold_if #(.SEL_W(3), .NUM_OUT(5)) bus_c ();

   decoder_nxm_hold #(.SEL_W(2), .NUM_OUT(4), .HOLD_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   decoder_nxm_hold #(.SEL_W(2), .NUM_OUT(4), .HOLD_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   decoder_nxm_hold #(.SEL_W(3), .NUM_OUT(5), .HOLD_CYCLES(4)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

   typedef struct {
      logic [7:0] y;
      logic       ov;
      logic       er;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int which, input logic [7:0] y, input logic ov, input logic er,
                       input int n);
      exp_t e;
      e.y  = y;
      e.ov = ov;
      e.er = er;
      for (int i = 0; i < n; i++) begin
         case (which)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
         endcase
      end
   endtask

   task automatic check_all();
      exp_t e;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         chk("a.y", 32'(bus_a.y), 32'(e.y));
         chk("a.out_valid", 32'(bus_a.out_valid), 32'(e.ov));
`ifdef DECODER_RANGE_CHECK_EN
         chk("a.err", 32'(bus_a.err), 32'(e.er));
`endif
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         chk("b.y", 32'(bus_b.y), 32'(e.y));
         chk("b.out_valid", 32'(bus_b.out_valid), 32'(e.ov));
`ifdef DECODER_RANGE_CHECK_EN
         chk("b.err", 32'(bus_b.err), 32'(e.er));
`endif
      end
      if (qc.size() > 0) begin
         e = qc.pop_front();
         chk("c.y", 32'(bus_c.y), 32'(e.y));
         chk("c.out_valid", 32'(bus_c.out_valid), 32'(e.ov));
`ifdef DECODER_RANGE_CHECK_EN
         chk("c.err", 32'(bus_c.err), 32'(e.er));
`endif
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst = 1'b1;
      bus_a.en = 1'b1; bus_a.in_valid = 1'b0; bus_a.sel = '0;
      bus_b.en = 1'b1; bus_b.in_valid = 1'b0; bus_b.sel = '0;
      bus_c.en = 1'b1; bus_c.in_valid = 1'b0; bus_c.sel = '0;
      cycle();
      cycle();

      // Reset values, in_ready forced low while rst is high
      push(0, 8'h00, 1'b0, 1'b0, 1);
      push(1, 8'h00, 1'b0, 1'b0, 1);
      push(2, 8'h00, 1'b0, 1'b0, 1);
      check_all();
      chk("a.rdy_rst", 32'(bus_a.in_ready), 32'd0);
      chk("c.rdy_rst", 32'(bus_c.in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("a.rdy_idle", 32'(bus_a.in_ready), 32'd1);

      // HOLD_CYCLES=1: back-to-back selects, one per cycle
      for (int s = 0; s < 4; s++) begin
         bus_a.in_valid = 1'b1;
         bus_a.sel      = 2'(s);
         push(0, 8'(4'b1000 >> s), 1'b1, 1'b0, 1);
         cycle();
      end
      bus_a.in_valid = 1'b0;
      push(0, 8'h00, 1'b0, 1'b0, 1);
      cycle();

      // HOLD_CYCLES=3: sel=2 held exactly 3 cycles, ready only on the last
      bus_b.in_valid = 1'b1;
      bus_b.sel      = 2'd2;
      push(1, 8'b0010, 1'b1, 1'b0, 1);
      cycle();
      bus_b.in_valid = 1'b0;
      chk("b.rdy_h1", 32'(bus_b.in_ready), 32'd0);
      push(1, 8'b0010, 1'b1, 1'b0, 1);
      cycle();
      chk("b.rdy_h2", 32'(bus_b.in_ready), 32'd0);
      push(1, 8'b0010, 1'b1, 1'b0, 1);
      cycle();
      chk("b.rdy_h3", 32'(bus_b.in_ready), 32'd1);
      push(1, 8'h00, 1'b0, 1'b0, 1);
      cycle();

      // HOLD_CYCLES=3: sel=1 then sel=3 pending, replaced with no gap
      bus_b.in_valid = 1'b1;
      bus_b.sel      = 2'd1;
      push(1, 8'b0100, 1'b1, 1'b0, 1);
      cycle();
      bus_b.sel = 2'd3;
      push(1, 8'b0100, 1'b1, 1'b0, 2);
      cycle();
      cycle();
      push(1, 8'b0001, 1'b1, 1'b0, 1);
      cycle();
      bus_b.in_valid = 1'b0;
      push(1, 8'b0001, 1'b1, 1'b0, 2);
      cycle();
      cycle();
      push(1, 8'h00, 1'b0, 1'b0, 1);
      cycle();

      // NUM_OUT=5, HOLD_CYCLES=4: out-of-range sel, then en drop in hold cycle 2
      bus_c.in_valid = 1'b1;
      bus_c.sel      = 3'd6;
      push(2, 8'h00, 1'b1, 1'b1, 1);
      cycle();
      bus_c.in_valid = 1'b0;
      push(2, 8'h00, 1'b1, 1'b1, 1);
      cycle();
      bus_c.en = 1'b0;
      #1;
      chk("c.rdy_en0", 32'(bus_c.in_ready), 32'd0);
      push(2, 8'h00, 1'b0, 1'b0, 1);
      cycle();
      chk("c.rdy_en0_idle", 32'(bus_c.in_ready), 32'd0);
      bus_c.en = 1'b1;
      #1;
      chk("c.rdy_en1", 32'(bus_c.in_ready), 32'd1);

      // NUM_OUT=5: top output (y[4] is the LSB) held 4 cycles
      bus_c.in_valid = 1'b1;
      bus_c.sel      = 3'd4;
      push(2, 8'b00001, 1'b1, 1'b0, 1);
      cycle();
      bus_c.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push(2, 8'b00001, 1'b1, 1'b0, 1);
         cycle();
      end
      push(2, 8'h00, 1'b0, 1'b0, 1);
      cycle();

      // Reset mid-hold with in_valid high: nothing accepted
      bus_b.in_valid = 1'b1;
      bus_b.sel      = 2'd0;
      push(1, 8'b1000, 1'b1, 1'b0, 1);
      cycle();
      rst            = 1'b1;
      bus_b.sel      = 2'd2;
      #1;
      chk("b.rdy_rst", 32'(bus_b.in_ready), 32'd0);
      push(1, 8'h00, 1'b0, 1'b0, 1);
      cycle();
      rst            = 1'b0;
      bus_b.in_valid = 1'b0;
      push(1, 8'h00, 1'b0, 1'b0, 1);
      cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
